// File: rtl/hs32_memarb_pkg.sv
// Shared constants and bus payload types for the hs32 two-port memory arbiter.
// Holds the arbiter state codes, owner codes and the latched memory command layout.
package hs32_memarb_pkg;

    localparam int unsigned XLEN = 32;

    // Arbiter FSM state codes
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Bus owner codes
    localparam logic OWN_F = 1'b0;
    localparam logic OWN_E = 1'b1;

    // Command latched from the winning requester and driven onto the memory bus
    typedef struct packed {
        logic            rw;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] dtw;
    } mem_cmd_t;

endpackage

// File: rtl/hs32_memarb.sv
// hs32_memarb: shares one 32-bit memory bus between instruction fetch (F) and the
// execute unit (E). Exec has priority; a streak limiter forces a waiting fetch through
// after MAX_STREAK consecutive exec grants. One transaction is outstanding at a time:
// IDLE (arbitrate) -> BUSY (wait for m_rdy) -> RESP (owner's rdy pulse) -> IDLE.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   f_req/f_addr    fetch request (read only)
//   f_dtr/f_rdy     fetch read data (held) and one-cycle completion pulse
//   flush           suppresses f_rdy of an in-flight fetch
//   e_req/e_rw/e_addr/e_dtw   exec request, direction, address, write data
//   e_dtr/e_rdy     exec read data (held) and one-cycle completion pulse
//   m_req/m_rw/m_addr/m_dtw   registered downstream memory request
//   m_dtr/m_rdy     memory read data and ready
module hs32_memarb
    import hs32_memarb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_dtr,
    output logic        f_rdy,
    input  logic        flush,
    input  logic        e_req,
    input  logic        e_rw,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_dtw,
    output logic [31:0] e_dtr,
    output logic        e_rdy,
    output logic        m_req,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    input  logic [31:0] m_dtr,
    input  logic        m_rdy
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                flush_pend_q, flush_pend_d;
    logic                m_req_q, m_req_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic [31:0]         f_dtr_q, f_dtr_d;
    logic [31:0]         e_dtr_q, e_dtr_d;

    logic                grant_e;
    logic                grant_f;
    logic                win_own;
    mem_cmd_t            win_cmd;
    logic [STREAK_W-1:0] streak_inc;

    // Arbitration: exec wins unless fetch is waiting and the exec streak is exhausted
    always_comb begin
        grant_e     = 1'b0;
        grant_f     = 1'b0;
        win_own     = OWN_F;
        win_cmd     = '0;
        if (e_req && !(f_req && (streak_q == STREAK_MAX))) begin
            grant_e      = 1'b1;
            win_own      = OWN_E;
            win_cmd.rw   = e_rw;
            win_cmd.addr = e_addr;
            win_cmd.dtw  = e_dtw;
        end else if (f_req) begin
            grant_f      = 1'b1;
            win_own      = OWN_F;
            win_cmd.rw   = 1'b0;
            win_cmd.addr = f_addr;
            win_cmd.dtw  = '0;
        end
    end

    // Saturating streak increment
    always_comb begin
        streak_inc = STREAK_MAX;
        if (streak_q < STREAK_MAX) begin
            streak_inc = streak_q + STREAK_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        streak_d     = streak_q;
        flush_pend_d = flush_pend_q;
        m_req_d      = m_req_q;
        cmd_d        = cmd_q;
        f_dtr_d      = f_dtr_q;
        e_dtr_d      = e_dtr_q;

        // A flush only matters while a fetch owns the bus
        if (flush && (owner_q == OWN_F) && (state_q != ARB_IDLE)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (grant_e || grant_f) begin
                    owner_d = win_own;
                    cmd_d   = win_cmd;
                    m_req_d = 1'b1;
                    state_d = ARB_BUSY;
                    // Streak counts exec grants only while fetch is kept waiting
                    streak_d = (grant_e && f_req) ? streak_inc : '0;
                end
            end
            ARB_BUSY: begin
                if (m_req_q && m_rdy) begin
                    m_req_d = 1'b0;
                    state_d = ARB_RESP;
                    if (!cmd_q.rw) begin
                        if (owner_q == OWN_E) begin
                            e_dtr_d = m_dtr;
                        end else begin
                            f_dtr_d = m_dtr;
                        end
                    end
                end
            end
            ARB_RESP: begin
                state_d      = ARB_IDLE;
                flush_pend_d = 1'b0;
            end
            default: begin
                state_d      = ARB_IDLE;
                m_req_d      = 1'b0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_F;
            streak_q     <= '0;
            flush_pend_q <= 1'b0;
            m_req_q      <= 1'b0;
            cmd_q        <= '0;
            f_dtr_q      <= '0;
            e_dtr_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            streak_q     <= streak_d;
            flush_pend_q <= flush_pend_d;
            m_req_q      <= m_req_d;
            cmd_q        <= cmd_d;
            f_dtr_q      <= f_dtr_d;
            e_dtr_q      <= e_dtr_d;
        end
    end

    // Completion pulses decode the RESP state; a flush in the RESP cycle itself
    // must still hide f_rdy, hence the direct flush term.
    assign e_rdy  = (state_q == ARB_RESP) && (owner_q == OWN_E);
    assign f_rdy  = (state_q == ARB_RESP) && (owner_q == OWN_F) && !flush_pend_q && !flush;

    assign f_dtr  = f_dtr_q;
    assign e_dtr  = e_dtr_q;
    assign m_req  = m_req_q;
    assign m_rw   = cmd_q.rw;
    assign m_addr = cmd_q.addr;
    assign m_dtw  = cmd_q.dtw;

endmodule
